// File: rtl/ps_pkg.sv
// Shared definitions for the processing-stage pixel blocks: frame defaults,
// RGB444 nibble layout and the small arithmetic helpers used by ps_sobel.
package ps_pkg;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int PIX_W     = 12;
    localparam int NIB_W     = 4;
    localparam int R_LSB     = 8;
    localparam int G_LSB     = 4;
    localparam int B_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } sobel_state_t;

    // One window column: rows (row-2, row-1, row) at a single col
    typedef struct packed {
        logic [NIB_W-1:0] top;
        logic [NIB_W-1:0] mid;
        logic [NIB_W-1:0] bot;
    } col3_t;

    function automatic logic [NIB_W-1:0] grey_of(input logic [PIX_W-1:0] pix);
        return pix[B_LSB +: NIB_W];
    endfunction

    // 1-2-1 weighted sum of three nibbles, max 60
    function automatic logic [6:0] sum121(input logic [NIB_W-1:0] a,
                                          input logic [NIB_W-1:0] b,
                                          input logic [NIB_W-1:0] c);
        return 7'(a) + {2'b00, b, 1'b0} + 7'(c);
    endfunction

    function automatic logic [NIB_W-1:0] mag_to_grey(input logic [7:0] mag);
        logic [5:0] q;
        q = mag[7:2];
        return (q > 6'd15) ? 4'hF : q[3:0];
    endfunction
endpackage

// File: rtl/ps_sobel_linebuf.sv
// Two-line grey buffer. Rows alternate between the even/odd memories; each
// access reads the old column (row-2, row-1) before overwriting it with row.
module ps_sobel_linebuf
    import ps_pkg::*;
#(
    parameter  int IMG_W = IMG_W_DEF,
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic             i_clk,
    input  logic             wr_en,
    input  logic             row_odd,
    input  logic [COL_W-1:0] col,
    input  logic [NIB_W-1:0] pix,
    output col3_t            tap
);
    logic [NIB_W-1:0] mem_even [IMG_W];
    logic [NIB_W-1:0] mem_odd  [IMG_W];
    logic [NIB_W-1:0] rd_even;
    logic [NIB_W-1:0] rd_odd;
    logic [NIB_W-1:0] pix_q;
    logic             odd_q;

    // The memory of the current row's parity holds row-2 and is overwritten
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            rd_even <= mem_even[col];
            rd_odd  <= mem_odd[col];
            pix_q   <= pix;
            odd_q   <= row_odd;
            if (row_odd)
                mem_odd[col] <= pix;
            else
                mem_even[col] <= pix;
        end
    end

    assign tap.top = odd_q ? rd_odd  : rd_even;
    assign tap.mid = odd_q ? rd_even : rd_odd;
    assign tap.bot = pix_q;
endmodule

// File: rtl/ps_sobel.sv
// Streaming 3x3 Sobel edge magnitude with per-frame passthrough mode,
// end-of-frame border drain and synchronous flush. Latency 2 cycles.
//
//   state | meaning
//   IDLE  | at (0,0), waiting for the first pixel of a frame
//   FILL  | Sobel frame, inputs before index IMG_W+1 produce no output
//   RUN   | every input triggers an output; returns to IDLE at frame end
//   (drain is a separate down-counter that may overlap IDLE/FILL)
module ps_sobel
    import ps_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int DATA_WIDTH = PIX_W
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int DRN_W = $clog2(IMG_W + 2);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             mode;
    logic [DRN_W-1:0] drain_cnt;
    sobel_state_t     state, state_nx;

    logic take, at_origin, last_col, last_row, frame_end, fill_done;
    logic drain_act, eff_mode, trig, win_en;

    assign take      = i_valid && !i_flush;
    assign at_origin = (col == '0) && (row == '0);
    assign last_col  = (col == COL_W'(IMG_W - 1));
    assign last_row  = (row == ROW_W'(IMG_H - 1));
    assign frame_end = last_col && last_row;
    assign fill_done = (row == ROW_W'(1)) && (col == '0);
    assign drain_act = (drain_cnt != '0);
    // A frame starting while the previous one drains keeps the old mode
    assign eff_mode  = (at_origin && !drain_act) ? i_enable : mode;
    assign trig      = (state == ST_RUN) && mode;
    assign win_en    = take && eff_mode;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (take) state_nx = eff_mode ? ST_FILL : ST_RUN;
            ST_FILL: if (take && fill_done) state_nx = ST_RUN;
            ST_RUN:  if (take && frame_end) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (i_flush)
            state_nx = ST_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            mode      <= 1'b0;
            drain_cnt <= '0;
        end else if (i_flush) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            mode      <= 1'b0;
            drain_cnt <= '0;
        end else begin
            state <= state_nx;
            if (drain_act)
                drain_cnt <= drain_cnt - DRN_W'(1);
            if (take) begin
                if (at_origin)
                    mode <= eff_mode;
                col <= last_col ? '0 : col + COL_W'(1);
                if (last_col)
                    row <= last_row ? '0 : row + ROW_W'(1);
                if (frame_end && trig)
                    drain_cnt <= DRN_W'(IMG_W + 1);
            end
        end
    end

    col3_t c2;

    ps_sobel_linebuf #(.IMG_W(IMG_W)) u_linebuf (
        .i_clk   (i_clk),
        .wr_en   (win_en),
        .row_odd (row[0]),
        .col     (col),
        .pix     (grey_of(i_data)),
        .tap     (c2)
    );

    col3_t                 c1, c0;
    logic [DATA_WIDTH-1:0] s1_pix;
    logic                  s1_valid, s1_pass, s1_border;

    always_ff @(posedge i_clk) begin
        if (win_en) begin
            c1 <= c2;
            c0 <= c1;
        end
        if (take)
            s1_pix <= i_data;
    end

    // Input (row,col) produces output (row-1,col-1); col 0/1 and row 1 land on the border
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid  <= 1'b0;
            s1_pass   <= 1'b0;
            s1_border <= 1'b0;
        end else if (i_flush) begin
            s1_valid  <= 1'b0;
            s1_pass   <= 1'b0;
            s1_border <= 1'b0;
        end else begin
            s1_valid  <= drain_act || (take && (!eff_mode || trig));
            s1_pass   <= take && !eff_mode;
            s1_border <= drain_act || (col == COL_W'(0)) || (col == COL_W'(1))
                         || (row == ROW_W'(1));
        end
    end

    logic [6:0]            gx_p, gx_n, gy_p, gy_n, ax, ay;
    logic [7:0]            mag;
    logic [NIB_W-1:0]      g;
    logic [DATA_WIDTH-1:0] sobel_pix;

    always_comb begin
        gx_p = sum121(c2.top, c2.mid, c2.bot);
        gx_n = sum121(c0.top, c0.mid, c0.bot);
        gy_p = sum121(c0.bot, c1.bot, c2.bot);
        gy_n = sum121(c0.top, c1.top, c2.top);
        ax   = (gx_p >= gx_n) ? gx_p - gx_n : gx_n - gx_p;
        ay   = (gy_p >= gy_n) ? gy_p - gy_n : gy_n - gy_p;
        mag  = {1'b0, ax} + {1'b0, ay};
        g    = s1_border ? '0 : mag_to_grey(mag);
        sobel_pix = '0;
        sobel_pix[R_LSB +: NIB_W] = g;
        sobel_pix[G_LSB +: NIB_W] = g;
        sobel_pix[B_LSB +: NIB_W] = g;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= s1_valid;
            if (s1_valid)
                o_data <= s1_pass ? s1_pix : sobel_pix;
        end
    end
endmodule
